// File: rtl/apple_ctrl.sv
// Apple lifecycle controller: eat detection, scoring, LFSR cell draw and
// rejection of cells under the snake body. APPLE_TIMEOUT_EN adds an idle-tick relocation timeout.
module apple_ctrl #(
  parameter int unsigned GRID_COLS = 64,
  parameter int unsigned GRID_ROWS = 48,
  parameter int unsigned SCORE_MAX = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned START_X   = 32,
  parameter int unsigned START_Y   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [6:0] head_x,
  input  logic [5:0] head_y,
  input  logic [7:0] snake_len,
  output logic       seg_rd_req,
  output logic [7:0] seg_addr,
  input  logic       seg_rd_valid,
  input  logic [6:0] seg_x,
  input  logic [5:0] seg_y,
  output logic [6:0] apple_x,
  output logic [5:0] apple_y,
  output logic       apple_valid,
  output logic       eaten,
  output logic [3:0] score,
  output logic       win,
  output logic       busy
);

  localparam logic [3:0] SCORE_LAST = 4'(SCORE_MAX - 1);

  typedef enum logic [2:0] {IDLE, DRAW, CHECK, PLACE, DONE} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [6:0]  cand_x;
  logic [5:0]  cand_y;
  logic [7:0]  last_idx;

  logic       lfsr_fb;
  logic [6:0] lfsr_x;
  logic [5:0] lfsr_y;
  logic       head_on_apple;
  logic       cand_ok;
  logic       xfer;
  logic       seg_hit;

`ifdef APPLE_TIMEOUT_EN
  localparam int unsigned TIMEOUT_TICKS = 64;
  logic [7:0] tick_cnt;
  logic       timeout;
  assign timeout = (32'(tick_cnt) + 32'd1) >= TIMEOUT_TICKS;
`endif

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign lfsr_x  = lfsr[6:0];
  assign lfsr_y  = lfsr[13:8];

  assign head_on_apple = (head_x == apple_x) && (head_y == apple_y);
  assign cand_ok = (32'(lfsr_x) < GRID_COLS) && (32'(lfsr_y) < GRID_ROWS) &&
                   !((lfsr_x == head_x) && (lfsr_y == head_y));
  assign xfer    = seg_rd_req && seg_rd_valid;
  assign seg_hit = (seg_x == cand_x) && (seg_y == cand_y);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      cand_x      <= 7'd0;
      cand_y      <= 6'd0;
      last_idx    <= 8'd0;
      seg_rd_req  <= 1'b0;
      seg_addr    <= 8'd0;
      apple_x     <= 7'(START_X);
      apple_y     <= 6'(START_Y);
      apple_valid <= 1'b1;
      eaten       <= 1'b0;
      score       <= 4'd0;
      win         <= 1'b0;
      busy        <= 1'b0;
`ifdef APPLE_TIMEOUT_EN
      tick_cnt    <= 8'd0;
`endif
    end else begin
      lfsr  <= {lfsr_fb, lfsr[15:1]};
      eaten <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && apple_valid && head_on_apple) begin
            eaten       <= 1'b1;
            apple_valid <= 1'b0;
            score       <= score + 4'd1;
            if (score == SCORE_LAST) begin
              win   <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= DRAW;
            end
          end
`ifdef APPLE_TIMEOUT_EN
          else if (tick && apple_valid && timeout) begin
            apple_valid <= 1'b0;
            busy        <= 1'b1;
            state       <= DRAW;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 8'd1;
          end
`endif
        end
        DRAW: begin
          if (cand_ok) begin
            cand_x   <= lfsr_x;
            cand_y   <= lfsr_y;
            seg_addr <= 8'd0;
            last_idx <= snake_len - 8'd1;
            if (snake_len != 8'd0) begin
              seg_rd_req <= 1'b1;
              state      <= CHECK;
            end else begin
              state <= PLACE;
            end
          end
        end
        // Address holds until the read completes; a hit restarts the draw
        CHECK: begin
          if (xfer) begin
            if (seg_hit) begin
              seg_rd_req <= 1'b0;
              state      <= DRAW;
            end else if (seg_addr == last_idx) begin
              seg_rd_req <= 1'b0;
              state      <= PLACE;
            end else begin
              seg_addr <= seg_addr + 8'd1;
            end
          end
        end
        PLACE: begin
          apple_x     <= cand_x;
          apple_y     <= cand_y;
          apple_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
`ifdef APPLE_TIMEOUT_EN
          tick_cnt    <= 8'd0;
`endif
        end
        DONE: begin
          apple_valid <= 1'b0;
          win         <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apple_ctrl.md
Name: apple_ctrl

Overview:
- Sequences apple lifecycle: detects eat, updates score, draws a new random grid cell from an LFSR, rejects cells under the snake body by scanning the segment store, then publishes the new apple.
- Sits between snake movement logic (head position, length, segment read port) and the renderer/score display.
- All coordinates are grid cells, not pixels.

Parameters:
- GRID_COLS, 64, number of grid columns; legal x is 0..GRID_COLS-1 (max 128).
- GRID_ROWS, 48, number of grid rows; legal y is 0..GRID_ROWS-1 (max 64).
- SCORE_MAX, 10, score at which the game is won (max 15).
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.
- START_X, 32, apple x after reset.
- START_Y, 24, apple y after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- tick  in  1  one-cycle game-step strobe
- head_x  in  7  snake head column
- head_y  in  6  snake head row
- snake_len  in  8  body segments stored, excluding head (0..255)
- seg_rd_req  out  1  segment read request
- seg_addr  out  8  segment index being read
- seg_rd_valid  in  1  segment read data valid
- seg_x  in  7  segment column
- seg_y  in  6  segment row
- apple_x  out  7  current apple column
- apple_y  out  6  current apple row
- apple_valid  out  1  apple is placed and drawable
- eaten  out  1  one-cycle pulse on eat
- score  out  4  apples eaten, saturating
- win  out  1  score reached SCORE_MAX
- busy  out  1  high in any state other than IDLE/DONE

Behaviour:
- Reset (sync, active-high): apple_x=START_X, apple_y=START_Y, apple_valid=1, score=0, eaten=0, win=0, seg_rd_req=0, seg_addr=0, lfsr=LFSR_SEED, state=IDLE. Reset mid-scan aborts immediately, and seg_rd_req is low the cycle after reset.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, including during reset release; never zero.
- IDLE: on tick with apple_valid=1 and head==apple, next cycle:
  - eaten=1 for one cycle, score+1, apple_valid=0.
  - If the new score==SCORE_MAX: win=1, go DONE. Else go DRAW.
  - tick without a match: no action.
- DRAW (1 cycle per attempt):
  - cand_x=lfsr[6:0], cand_y=lfsr[13:8].
  - Reject and stay in DRAW if cand_x>=GRID_COLS, cand_y>=GRID_ROWS, or cand==head.
  - Else latch cand, idx=0. Go CHECK if snake_len>0, else PLACE.
- CHECK: drive seg_rd_req=1, seg_addr=idx.
  - A transfer completes in the cycle where seg_rd_req and seg_rd_valid are both high. Valid may arrive in the same cycle as req or any later cycle; seg_addr is held stable until completion.
  - On completion, if seg==cand: drop req, go DRAW.
  - Else if idx==snake_len-1: drop req, go PLACE.
  - Else idx+1; the next address is presented the following cycle.
  - snake_len is sampled on entry to CHECK; changes during a scan are ignored.
- PLACE (1 cycle): apple_x/y<=cand, apple_valid=1, go IDLE.
- Ticks arriving while busy are ignored; no eat is possible then because apple_valid=0.
- DONE: apple_valid=0, win=1, score held; only reset exits.
- Score saturates at SCORE_MAX and never wraps.
- No retry limit: if the grid is full, DRAW/CHECK loops indefinitely. With default grid sizes and snake_len<=255, a free cell always exists.

Optional Feature:
- Macro: APPLE_TIMEOUT_EN.
- Defined: adds localparam TIMEOUT_TICKS=64 and an 8-bit tick counter, cleared on PLACE and on reset, incremented on each tick in IDLE. When it reaches TIMEOUT_TICKS without an eat:
  - apple_valid=0, go DRAW; no score change, no eaten pulse.
  - An eat on the same tick as timeout takes priority.
- Undefined: no counter; the apple stays until eaten.

Test Plan:
- Reset, then tick with head=(32,24) -> next cycle eaten=1 for exactly 1 cycle, score=1, apple_valid=0, busy=1. Apple is republished within bounded cycles with x<64, y<48, not equal to (32,24).
- snake_len=3 with segments at (5,5),(6,5),(7,5); force cand=(6,5) via LFSR_SEED -> seg index 1 match, return to DRAW. The final apple avoids all three segments and the head.
- Segment memory responds with 0, 1 and 3 cycles of latency -> seg_addr stable until valid; each index read once; results identical across latencies.
- Ten successive eats -> score=10, win=1, DONE, apple_valid=0. A further tick with head on the old apple -> score stays 10, no eaten pulse.
- Assert reset during CHECK with seg_rd_req=1 -> next cycle seg_rd_req=0, apple=(32,24), apple_valid=1, score=0.
- With APPLE_TIMEOUT_EN, 64 ticks with head away from the apple -> apple relocates, score unchanged, no eaten pulse. An eat exactly on tick 64 -> eaten=1, score+1.
